// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with one outstanding request and IF/ID register.
// Optional perf counters (StallCycles, RedirectCount) are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallFetch,
    input  logic        StallDecode,
    input  logic        FlushDecode,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic        IMemRvalid,
    input  logic [31:0] IMemRdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] RedirectCount
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc4d_q, pc4d_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] resp_word;
    logic        accept;
    logic        have_word;
    logic        consume;

    assign IMemReq   = !rst && (state_q == S_REQ) && !StallFetch;
    assign IMemAddr  = pc_q;
    assign FetchBusy = (state_q == S_WAIT) || (state_q == S_DRAIN) ||
                       ((state_q == S_REQ) && !IMemReady);
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pc4d_q;
    assign ValidD    = valid_q;

    // A word is consumed (PC advances) when it reaches IF/ID or is flushed away there.
    assign pc_plus4  = pc_q + 32'd4;
    assign accept    = IMemReq && IMemReady;
    assign resp_word = (state_q == S_HOLD) ? hold_q : IMemRdata;
    assign have_word = ((state_q == S_WAIT) && IMemRvalid) || (state_q == S_HOLD);
    assign consume   = have_word && !PCSrcE && (!StallDecode || FlushDecode);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pc4d_d  = pc4d_q;
        valid_d = valid_q;

        case (state_q)
            S_REQ: begin
                if (accept) state_d = PCSrcE ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (IMemRvalid) begin
                    if (consume || PCSrcE) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = IMemRdata;
                    end
                end else if (PCSrcE) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (consume || PCSrcE) begin
                    state_d = S_REQ;
                    hold_d  = '0;
                end
            end
            default: begin
                if (IMemRvalid) state_d = S_REQ;
            end
        endcase

        if (PCSrcE)       pc_d = PCTargetE;
        else if (consume) pc_d = pc_plus4;

        if (FlushDecode) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (consume) begin
            instr_d = resp_word;
            pcd_d   = pc_q;
            pc4d_d  = pc_plus4;
            valid_d = 1'b1;
        end else if (!StallDecode) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if ((FetchBusy || StallFetch) && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (PCSrcE && (redir_cnt_q != 32'hFFFF_FFFF))                    redir_cnt_d = redir_cnt_q + 32'd1;
    end

    assign StallCycles   = stall_cnt_q;
    assign RedirectCount = redir_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // An in-flight response still arrives after reset and must be swallowed.
            if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !IMemRvalid) state_q <= S_DRAIN;
            else                                                             state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pc4d_q  <= '0;
            valid_q <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pc4d_q  <= pc4d_d;
            valid_q <= valid_d;
`ifdef FETCH_PERF_CNT_EN
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
`endif
        end
    end

endmodule
